// File: rtl/noc_pkg.sv
// Shared router-wide sizing constants for the input-port flit buffers.
// Router instances pass these to noc_port_fifo as DATA_W and DEPTH.
package noc_pkg;

    localparam int FLIT_W     = 8;
    localparam int FIFO_DEPTH = 8;

endpackage

// File: rtl/noc_fifo_mem.sv
// DEPTH x DATA_W flit storage with one write port and one registered read port.
// Pointer, occupancy and flag logic live in noc_port_fifo.
module noc_fifo_mem
    import noc_pkg::*;
#(
    parameter int DATA_W = FLIT_W,
    parameter int DEPTH  = FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array and its read register have no reset; a reset on storage
    // would block RAM inference and buys nothing, since the top masks rdata.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/noc_port_fifo.sv
// Router input-port flit FIFO: occupancy-decoded flags, almost-full back-pressure,
// synchronous flush and sticky overflow/underflow flags.
module noc_port_fifo
    import noc_pkg::*;
#(
    parameter int DATA_W   = FLIT_W,
    parameter int DEPTH    = FIFO_DEPTH,
    parameter int AFULL_TH = DEPTH - 2,
    parameter int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic [CNT_W-1:0]  count,
    output logic              ovf,
    output logic              udf
);

    localparam int              PTR_W     = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_TH);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              rd_acc;
    logic              wr_acc;
    logic              rd_zero;
    logic [DATA_W-1:0] mem_rdata;

    assign full        = (count == FULL_CNT);
    assign empty       = (count == '0);
    assign almost_full = (count >= AFULL_CNT);

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);

    noc_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk    (clk),
        .we     (wr_acc && !flush),
        .waddr  (wr_ptr),
        .wdata  (wr_data),
        .re     (rd_acc && !flush),
        .raddr  (rd_ptr),
        .rdata  (mem_rdata)
    );

    // rd_zero stands in for a reset/flush of the unreset memory read register.
    assign rd_data = rd_zero ? '0 : mem_rdata;

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            rd_zero  <= 1'b1;
            ovf      <= 1'b0;
            udf      <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            rd_zero  <= 1'b1;
            ovf      <= 1'b0;
            udf      <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) begin
                rd_zero <= 1'b0;
                rd_ptr  <= rd_ptr + PTR_W'(1);
            end
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (wr_acc && !rd_acc) begin
                count <= count + CNT_W'(1);
            end else if (rd_acc && !wr_acc) begin
                count <= count - CNT_W'(1);
            end
            if (wr_en && !wr_acc) begin
                ovf <= 1'b1;
            end
            if (rd_en && !rd_acc) begin
                udf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_noc_port_fifo.sv
// Directed bench for noc_port_fifo (DATA_W=8, DEPTH=8, AFULL_TH=6): expected read
// flits go into a queue; a negedge monitor pops and compares on every rd_valid.
module tb_noc_port_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic [3:0] count;
    logic       ovf;
    logic       udf;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [7:0] exp_q [$];

    noc_port_fifo #(
        .DATA_W   (8),
        .DEPTH    (8),
        .AFULL_TH (6)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .count       (count),
        .ovf         (ovf),
        .udf         (udf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; returns #1 after the rising edge with strobes low.
    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic f = 1'b0);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        flush   = f;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        flush = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " count"},       32'(count),       32'd0);
        check({tag, " empty"},       32'(empty),       32'd1);
        check({tag, " full"},        32'(full),        32'd0);
        check({tag, " almost_full"}, 32'(almost_full), 32'd0);
        check({tag, " rd_valid"},    32'(rd_valid),    32'd0);
        check({tag, " rd_data"},     32'(rd_data),     32'd0);
        check({tag, " ovf"},         32'(ovf),         32'd0);
        check({tag, " udf"},         32'(udf),         32'd0);
    endtask

    // Scoreboard monitor: every presented flit must match the oldest expected one.
    initial begin
        forever begin
            @(negedge clk);
            if (rd_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected rd_valid", 32'(rd_data), 32'hFFFF_FFFF);
                end else begin
                    check("rd_data scoreboard", 32'(rd_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        #13;
        check_reset_values("reset");
        @(negedge clk);
        rst = 1'b0;

        // Fill 0x11..0x18: almost_full from count 6, full at 8.
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 8'(8'h10 + i), 1'b0);
            check("fill count", 32'(count), 32'(i));
            check("fill almost_full", 32'(almost_full), 32'(i >= 6));
            check("fill full", 32'(full), 32'(i == 8));
        end
        for (int i = 1; i <= 8; i++) begin
            exp_q.push_back(8'(8'h10 + i));
            step(1'b0, 8'h00, 1'b1);
            check("drain rd_valid", 32'(rd_valid), 32'd1);
            check("drain count", 32'(count), 32'(8 - i));
        end
        check("drain empty", 32'(empty), 32'd1);
        step(1'b0, 8'h00, 1'b0);
        check("idle rd_valid", 32'(rd_valid), 32'd0);

        // Wrap-around: write 5, read 5, write 6 (pointers wrap past 7), read 6.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h21 + i), 1'b0);
        check("wrap count5", 32'(count), 32'd5);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(8'(8'h21 + i));
            step(1'b0, 8'h00, 1'b1);
        end
        check("wrap empty", 32'(empty), 32'd1);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 8'(8'h31 + i), 1'b0);
            check("wrap write count", 32'(count), 32'(i + 1));
        end
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(8'(8'h31 + i));
            step(1'b0, 8'h00, 1'b1);
            check("wrap read count", 32'(count), 32'(5 - i));
        end

        // Full with simultaneous read+write, then a lone write while full.
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h41 + i), 1'b0);
        exp_q.push_back(8'h41);
        step(1'b1, 8'hAA, 1'b1);
        check("full rw count", 32'(count), 32'd8);
        check("full rw full", 32'(full), 32'd1);
        check("full rw ovf", 32'(ovf), 32'd0);
        step(1'b1, 8'hBB, 1'b0);
        check("overflow ovf", 32'(ovf), 32'd1);
        check("overflow count", 32'(count), 32'd8);
        for (int i = 0; i < 7; i++) exp_q.push_back(8'(8'h42 + i));
        exp_q.push_back(8'hAA);
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);
        check("post-full empty", 32'(empty), 32'd1);
        check("ovf sticky", 32'(ovf), 32'd1);

        // Empty with simultaneous read+write: write only, read rejected.
        step(1'b1, 8'h5C, 1'b1);
        check("empty rw count", 32'(count), 32'd1);
        check("empty rw rd_valid", 32'(rd_valid), 32'd0);
        check("empty rw udf", 32'(udf), 32'd1);
        exp_q.push_back(8'h5C);
        step(1'b0, 8'h00, 1'b1);
        check("5C count", 32'(count), 32'd0);

        // Flush at count 4 with wr_en=rd_en=1 the same cycle.
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h61 + i), 1'b0);
        check("preflush count", 32'(count), 32'd4);
        step(1'b1, 8'hEE, 1'b1, 1'b1);
        check("flush count", 32'(count), 32'd0);
        check("flush empty", 32'(empty), 32'd1);
        check("flush rd_valid", 32'(rd_valid), 32'd0);
        check("flush rd_data", 32'(rd_data), 32'd0);
        check("flush ovf", 32'(ovf), 32'd0);
        check("flush udf", 32'(udf), 32'd0);
        step(1'b1, 8'h77, 1'b0);
        exp_q.push_back(8'h77);
        step(1'b0, 8'h00, 1'b1);

        // Asynchronous reset mid-burst at count 3, with udf set beforehand.
        step(1'b0, 8'h00, 1'b1);
        check("pre-rst udf", 32'(udf), 32'd1);
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h81 + i), 1'b0);
        check("pre-rst count", 32'(count), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("async rst");
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 8'h91, 1'b0);
        check("post-rst count", 32'(count), 32'd1);
        exp_q.push_back(8'h91);
        step(1'b0, 8'h00, 1'b1);
        check("post-rst empty", 32'(empty), 32'd1);

        step(1'b0, 8'h00, 1'b0);
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/noc_port_fifo.md
# noc_port_fifo

Parametrised input-port flit buffer for the router: one per router input channel, between the link receiver and the route/arbitration stage. It replaces the fixed 8×8 port FIFO with configurable width and depth, same-cycle-accurate full/empty flags, an almost-full output for link back-pressure, a synchronous flush, and sticky overflow/underflow error flags.

## Interface
- DATA_W, 8, flit width in bits
- DEPTH, 8, number of entries; power of two, ≥ 2
- AFULL_TH, DEPTH-2, occupancy at or above which almost_full asserts; 1 ≤ AFULL_TH ≤ DEPTH
- CNT_W, $clog2(DEPTH+1), derived width of count; not overridden
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous clear of the buffer contents and error flags
- wr_en  in  1  write request
- wr_data  in  DATA_W  flit to write
- rd_en  in  1  read request
- rd_data  out  DATA_W  registered read flit
- rd_valid  out  1  rd_data was loaded by a read accepted in the previous cycle
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AFULL_TH
- count  out  CNT_W  current occupancy
- ovf  out  1  sticky: a write was rejected
- udf  out  1  sticky: a read was rejected

## Operation
- Reset values: rd_data 0, rd_valid 0, count 0, empty 1, full 0, almost_full 0 (or 1 only if AFULL_TH == 0, which is illegal), ovf 0, udf 0, both pointers 0. Memory contents are not reset.
- rd_acc = rd_en && !empty.
- wr_acc = wr_en && (!full || rd_acc). A write to a full FIFO succeeds only when a read is accepted in the same cycle.
- On wr_acc: mem[wr_ptr] <= wr_data; wr_ptr increments by 1 modulo DEPTH (natural wrap, $clog2(DEPTH) bits).
- On rd_acc: rd_data <= mem[rd_ptr]; rd_ptr increments modulo DEPTH; rd_valid <= 1. Otherwise rd_valid <= 0 and rd_data holds its value.
- count update: +1 when only wr_acc, −1 when only rd_acc, unchanged when both or neither.
- Simultaneous read and write on an empty FIFO: the write is accepted, the read is rejected (no bypass path), count becomes 1, and udf sets.
- Simultaneous read and write on a full FIFO: both are accepted and count stays DEPTH.
- ovf sets on wr_en && !wr_acc. udf sets on rd_en && !rd_acc. Both stay set until flush or rst.
- Flush has priority over all other activity in the same cycle. It sets pointers, count, rd_valid, ovf, udf and rd_data to 0. wr_en and rd_en are ignored in that cycle and no error flag sets.
- full, empty and almost_full are decoded combinationally from the count register, so they always reflect the current occupancy with no cycle of lag.

## Timing
- Write-to-read latency: a flit written at edge N can be accepted by a read at edge N+1, because empty deasserts after edge N. It appears on rd_data with rd_valid after edge N+1.
- Read latency: rd_data and rd_valid become valid one cycle after rd_en is sampled with rd_acc.
- Flags and count change only on clock edges, or asynchronously on rst.
- rst asserted mid-operation clears state immediately. The first accepted write after rst deasserts lands in entry 0.
- No combinational path from rd_en or wr_en to any output.

## Structure
- Shared package noc_pkg holds FLIT_W (default 8) and FIFO_DEPTH (default 8). Router instances pass these as DATA_W and DEPTH.
- Sub-module noc_fifo_mem: a DEPTH×DATA_W register array with one write port and one registered read port (we, waddr, wdata, re, raddr, rdata). The pointer, count and flag logic stays in noc_port_fifo.

## Test plan
- Reset, then write 0x11..0x18 with DEPTH=8 -> full=1 and count=8 after the 8th edge; almost_full first asserts when count=6. Reading 8 times returns 0x11..0x18 in order, each with rd_valid one cycle later, and ends with empty=1.
- Wrap-around: write 5, read 5, write 6 -> the pointers wrap and the reads return the 6 new flits in order with count correct at every edge.
- Full with wr_en=rd_en=1 and wr_data=0xAA -> count stays 8, the oldest flit is output, and 0xAA later appears in FIFO order. A write alone while full sets ovf and count stays 8.
- Empty with wr_en=rd_en=1 and wr_data=0x5C -> count=1, rd_valid=0, and udf=1. The next read returns 0x5C.
- Flush at count=4 while wr_en=rd_en=1 -> count=0, empty=1, rd_valid=0, and ovf/udf cleared. The next write of 0x77 is read back as 0x77.
- rst pulsed mid-burst (count=3) asynchronously between edges -> all outputs take their reset values immediately, and operation resumes normally from entry 0.
